// File: rtl/data_mem_responder_if.sv
// CPU data-port bus plus TX drain handshake between the CPU/consumer side and the
// data-memory responder.
interface data_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_write;
  logic [31:0] rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  modport master (
    output addr, wdata, mem_write, tx_ready,
    input  rdata, tx_data, tx_valid, irq
  );

  modport slave (
    input  addr, wdata, mem_write, tx_ready,
    output rdata, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte/half stores, plus an MMIO page holding a
// cycle counter, compare/IRQ pair and a TX FIFO drained over valid/ready.
module data_mem_responder #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [31:0]        ram [2**RAM_AW];
  logic [31:0]        fifo_mem [DEPTH];
  logic [31:0]        cycle;
  logic [31:0]        compare;
  logic               flag;
  logic               ovf;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic              is_mmio;
  logic [7:0]        offset;
  logic              mmio_wr;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              full;
  logic              empty;
  logic              push;
  logic              do_push;
  logic              do_pop;
  logic [31:0]       status;

  assign is_mmio = (bus.addr[31:8] == MMIO_BASE[31:8]);
  assign offset  = bus.addr[7:0];
  // MMIO stores are dropped during reset, RAM stores are not.
  assign mmio_wr = is_mmio && (bus.mem_write == 2'b01) && !rst;
  assign ram_we  = !is_mmio && (bus.mem_write != 2'b00);
  assign ram_idx = bus.addr[RAM_AW+1:2];

  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = mmio_wr && (offset == 8'h04);
  assign do_push = push && !full;
  assign do_pop  = !empty && bus.tx_ready;
  assign status  = {24'b0, 5'(count), ovf, empty, full};

  always_comb begin
    be = 4'b0000;
    wd = bus.wdata;
    unique case (bus.mem_write)
      2'b01: be = 4'b1111;
      2'b10: begin
        be = bus.addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.wdata[15:0]}};
      end
      2'b11: begin
        be = 4'b0001 << bus.addr[1:0];
        wd = {4{bus.wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[ram_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle   <= '0;
      compare <= 32'hFFFFFFFF;
      flag    <= 1'b0;
      ovf     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (mmio_wr && offset == 8'h0C) compare <= bus.wdata;
      // A match in the same cycle as a W1C clear wins.
      if (cycle == compare) flag <= 1'b1;
      else if (mmio_wr && offset == 8'h10 && bus.wdata[0]) flag <= 1'b0;
      if (push && full) ovf <= 1'b1;
      else if (mmio_wr && offset == 8'h08) ovf <= 1'b0;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rdata = ram[ram_idx];
    if (is_mmio) begin
      unique case (offset)
        8'h00:   bus.rdata = cycle;
        8'h08:   bus.rdata = status;
        8'h0C:   bus.rdata = compare;
        8'h10:   bus.rdata = {31'b0, flag};
        default: bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.tx_data  = empty ? 32'h0 : fifo_mem[rd_ptr];
  assign bus.tx_valid = !empty;
  assign bus.irq      = flag;
endmodule
